// File: rtl/bcd_digit_serial_adder.sv
// rtl/bcd_digit_serial_adder.sv - digit-serial BCD adder controller driving an external 4-bit adder
// Optional invalid-digit check: define BCD_DIGIT_CHECK_EN.
module bcd_digit_serial_adder #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   op_a,
  input  logic [4*NDIGITS-1:0]   op_b,
  input  logic                   cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout,
  output logic                   err
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          cout_reg;

  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [4:0]    z;
  logic [3:0]    digit;
  logic          dcarry;
  logic          last;

  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (cnt == CW'(i)) begin
        a_dig = a_reg[4*i +: 4];
        b_dig = b_reg[4*i +: 4];
      end
    end
  end

  // Decimal correction: for z in 10..19, (z + 6) mod 16 equals z - 10.
  always_comb begin
    z = {add_cout, add_s};
    if (z > 5'd9) begin
      digit  = add_s + 4'd6;
      dcarry = 1'b1;
    end else begin
      digit  = add_s;
      dcarry = 1'b0;
    end
  end

  assign last    = (cnt == CW'(NDIGITS - 1));
  assign add_a   = (state == RUN) ? a_dig : 4'd0;
  assign add_b   = (state == RUN) ? b_dig : 4'd0;
  assign add_cin = (state == RUN) ? carry : 1'b0;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign sum     = sum_reg;
  assign cout    = cout_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            a_reg    <= op_a;
            b_reg    <= op_b;
            carry    <= cin;
            cnt      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (cnt == CW'(i)) sum_reg[4*i +: 4] <= digit;
          end
          carry <= dcarry;
          if (last) begin
            state    <= DONE;
            cout_reg <= dcarry;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (state == IDLE && start) begin
      err_reg <= 1'b0;
    end else if (state == RUN && (a_dig > 4'd9 || b_dig > 4'd9)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule
